// File: rtl/lpix_burst_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lpix_burst_pkg
//  Description : Shared definitions for the lpix burst bridge. Holds the
//                fixed parcel field widths, the parcel width helper functions
//                and the issue state machine encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package lpix_burst_pkg;

    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;

    // Request parcel, MSB to LSB: {burden, write, len, size, burst, wstrb, wdata, addr}
    function automatic int bw_qparcel(input int bw_addr, input int bw_data, input int bw_burden);
        return bw_burden + 1 + LEN_W + SIZE_W + BURST_W + (bw_data / 8) + bw_data + bw_addr;
    endfunction

    // Response parcel, MSB to LSB: {burden, error, rdata}
    function automatic int bw_yparcel(input int bw_data, input int bw_burden);
        return bw_burden + 1 + bw_data;
    endfunction

    typedef enum logic [0:0] {
        ST_HEAD   = 1'b0,   // queue head is the first beat of a transaction
        ST_WBURST = 1'b1    // streaming the remaining beats of a write burst
    } issue_state_t;

endpackage
`default_nettype wire

// File: rtl/lpix_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : lpix_sync_fifo
//  Description : Single-clock FIFO with first-word-fall-through read data.
//  Ports       : clk, rstnn (async active-low), i_clear (sync flush),
//                i_push/i_push_data, i_pop/o_pop_data, o_empty, o_full.
//                Pushes while full and pops while empty are ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module lpix_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstnn,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] C_LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [AW-1:0] f_next(input logic [AW-1:0] p);
        return (p == C_LAST_PTR) ? '0 : p + AW'(1);
    endfunction

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == C_DEPTH);
    assign w_do_push  = i_push & ~o_full;
    assign w_do_pop   = i_pop & ~o_empty;
    assign o_pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= f_next(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/lpix_burst_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : lpix_burst_bridge
//  Description : Buffers master request beats, forwards them to the slave
//                while limiting the number of unanswered transactions, and
//                marks the last response beat of each transaction.
//  Ports       : clk, rstnn (async active-low), clear (sync flush),
//                enable (admit new transactions),
//                m_q* master request in, s_q* slave request out (+s_qlast),
//                s_y* slave response in, m_y* master response out
//                (m_yparcel = {ylast, s_yparcel}).
//  Revision    : 1.0  initial release
// ============================================================================
module lpix_burst_bridge
    import lpix_burst_pkg::*;
#(
    parameter  int BW_ADDR         = 32,
    parameter  int BW_DATA         = 32,
    parameter  int BW_BURDEN       = 1,
    parameter  int QUEUE_DEPTH     = 4,
    parameter  int MAX_OUTSTANDING = 8,
    localparam int BW_QPARCEL      = bw_qparcel(BW_ADDR, BW_DATA, BW_BURDEN),
    localparam int BW_YPARCEL      = bw_yparcel(BW_DATA, BW_BURDEN)
) (
    input  logic                  clk,
    input  logic                  rstnn,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  m_qvalid,
    output logic                  m_qready,
    input  logic [BW_QPARCEL-1:0] m_qparcel,
    output logic                  s_qvalid,
    input  logic                  s_qready,
    output logic [BW_QPARCEL-1:0] s_qparcel,
    output logic                  s_qlast,
    input  logic                  s_yvalid,
    output logic                  s_yready,
    input  logic [BW_YPARCEL-1:0] s_yparcel,
    output logic                  m_yvalid,
    input  logic                  m_yready,
    output logic [BW_YPARCEL:0]   m_yparcel
);
    localparam int OFF_LEN = BW_ADDR + BW_DATA + (BW_DATA / 8) + BURST_W + SIZE_W;
    localparam int OFF_WR  = OFF_LEN + LEN_W;
    localparam int TRK_W   = 1 + LEN_W;

    issue_state_t     r_state, w_state_nxt;
    logic [LEN_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
    logic [LEN_W-1:0] r_rsp_cnt;

    logic             w_req_empty, w_req_full, w_req_pop;
    logic             w_head_write;
    logic [LEN_W-1:0] w_head_len;

    logic             w_trk_push, w_trk_pop, w_trk_empty, w_trk_full;
    logic [TRK_W-1:0] w_trk_head;
    logic             w_trk_write;
    logic [LEN_W-1:0] w_trk_len;
    logic             w_ylast, w_rsp_hs;

    // ---------------- request queue ----------------
    // rstnn gates ready so the master never sees a handshake while reset is held.
    assign m_qready = rstnn & enable & ~clear & ~w_req_full;

    lpix_sync_fifo #(
        .WIDTH (BW_QPARCEL),
        .DEPTH (QUEUE_DEPTH)
    ) u_req_fifo (
        .clk         (clk),
        .rstnn       (rstnn),
        .i_clear     (clear),
        .i_push      (m_qvalid & m_qready),
        .i_push_data (m_qparcel),
        .i_pop       (w_req_pop),
        .o_pop_data  (s_qparcel),
        .o_empty     (w_req_empty),
        .o_full      (w_req_full)
    );

    assign w_head_write = s_qparcel[OFF_WR];
    assign w_head_len   = s_qparcel[OFF_LEN +: LEN_W];
    assign w_req_pop    = s_qvalid & s_qready;

    // ---------------- issue FSM ----------------
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_state    <= ST_HEAD;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        s_qvalid       = 1'b0;
        s_qlast        = 1'b0;
        w_trk_push     = 1'b0;
        if (clear) begin
            w_state_nxt    = ST_HEAD;
            w_beat_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_HEAD: begin
                    // Only a new transaction is subject to enable and the outstanding limit.
                    s_qvalid = ~w_req_empty & enable & ~w_trk_full;
                    // A read is a single request beat whatever its len.
                    s_qlast  = s_qvalid & (~w_head_write | (w_head_len == '0));
                    if (s_qvalid && s_qready) begin
                        w_trk_push = 1'b1;
                        if (w_head_write && (w_head_len != '0)) begin
                            w_beat_cnt_nxt = LEN_W'(1);
                            w_state_nxt    = ST_WBURST;
                        end
                    end
                end
                ST_WBURST: begin
                    // Remaining write beats belong to an admitted transaction, so they drain freely.
                    s_qvalid = ~w_req_empty;
                    s_qlast  = s_qvalid & (r_beat_cnt == w_head_len);
                    if (s_qvalid && s_qready) begin
                        if (s_qlast) begin
                            w_beat_cnt_nxt = '0;
                            w_state_nxt    = ST_HEAD;
                        end else begin
                            w_beat_cnt_nxt = r_beat_cnt + LEN_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt    = ST_HEAD;
                    w_beat_cnt_nxt = '0;
                end
            endcase
        end
    end

    // ---------------- tracking FIFO and response path ----------------
    lpix_sync_fifo #(
        .WIDTH (TRK_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_trk_fifo (
        .clk         (clk),
        .rstnn       (rstnn),
        .i_clear     (clear),
        .i_push      (w_trk_push),
        .i_push_data ({w_head_write, w_head_len}),
        .i_pop       (w_trk_pop),
        .o_pop_data  (w_trk_head),
        .o_empty     (w_trk_empty),
        .o_full      (w_trk_full)
    );

    assign w_trk_write = w_trk_head[TRK_W-1];
    assign w_trk_len   = w_trk_head[LEN_W-1:0];

    // With nothing tracked, responses are held at the slave rather than dropped.
    assign s_yready  = m_yready & ~w_trk_empty;
    assign m_yvalid  = s_yvalid & ~w_trk_empty;
    assign w_rsp_hs  = s_yvalid & s_yready;
    assign w_ylast   = ~w_trk_empty & (w_trk_write | (r_rsp_cnt == w_trk_len));
    assign w_trk_pop = w_rsp_hs & w_ylast;
    assign m_yparcel = {w_ylast, s_yparcel};

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_rsp_cnt <= '0;
        end else if (clear) begin
            r_rsp_cnt <= '0;
        end else if (w_rsp_hs) begin
            r_rsp_cnt <= w_ylast ? '0 : r_rsp_cnt + LEN_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lpix_burst_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lpix_burst_bridge
//  Description : Directed self-checking bench for lpix_burst_bridge
//                (QUEUE_DEPTH=8, MAX_OUTSTANDING=2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lpix_burst_bridge;
    localparam int QW = 83;
    localparam int YW = 34;

    logic          clk = 1'b0;
    logic          rstnn, clear, enable;
    logic          m_qvalid, m_qready, s_qvalid, s_qready, s_qlast;
    logic          s_yvalid, s_yready, m_yvalid, m_yready;
    logic [QW-1:0] m_qparcel, s_qparcel;
    logic [YW-1:0] s_yparcel;
    logic [YW:0]   m_yparcel;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lpix_burst_bridge #(
        .BW_ADDR         (32),
        .BW_DATA         (32),
        .BW_BURDEN       (1),
        .QUEUE_DEPTH     (8),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk       (clk),
        .rstnn     (rstnn),
        .clear     (clear),
        .enable    (enable),
        .m_qvalid  (m_qvalid),
        .m_qready  (m_qready),
        .m_qparcel (m_qparcel),
        .s_qvalid  (s_qvalid),
        .s_qready  (s_qready),
        .s_qparcel (s_qparcel),
        .s_qlast   (s_qlast),
        .s_yvalid  (s_yvalid),
        .s_yready  (s_yready),
        .s_yparcel (s_yparcel),
        .m_yvalid  (m_yvalid),
        .m_yready  (m_yready),
        .m_yparcel (m_yparcel)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // {burden, write, len, size=2, burst=1, wstrb=F, wdata, addr}
    function automatic logic [QW-1:0] mkq(input logic wr, input logic [7:0] len,
                                          input logic [31:0] wdata, input logic [31:0] addr);
        return {len[0], wr, len, 3'd2, 2'd1, 4'hF, wdata, addr};
    endfunction

    function automatic logic [YW-1:0] mky(input logic err, input logic [31:0] rdata);
        return {rdata[0], err, rdata};
    endfunction

    task automatic expect_q(input string tag, input logic v, input logic l, input logic [QW-1:0] p);
        chk({tag, "_qvalid"}, s_qvalid, v);
        chk({tag, "_qlast"}, s_qlast, l);
        if (v) chk({tag, "_qparcel"}, s_qparcel, p);
    endtask

    task automatic expect_y(input string tag, input logic last, input logic [YW-1:0] y);
        chk({tag, "_yvalid"}, m_yvalid, 1'b1);
        chk({tag, "_yparcel"}, m_yparcel, {last, y});
    endtask

    logic [QW-1:0] rd, rd2, rd3;
    logic [QW-1:0] w [5];

    initial begin
        rstnn = 1'b0; clear = 1'b0; enable = 1'b1;
        m_qvalid = 1'b0; m_qparcel = '0; s_qready = 1'b1;
        s_yvalid = 1'b1; s_yparcel = mky(1'b0, 32'h11); m_yready = 1'b1;

        // ---- reset state ----
        #1;
        chk("rst_m_qready", m_qready, 1'b0);
        chk("rst_s_qvalid", s_qvalid, 1'b0);
        chk("rst_s_qlast", s_qlast, 1'b0);
        chk("rst_m_yvalid", m_yvalid, 1'b0);
        chk("rst_s_yready", s_yready, 1'b0);

        // ---- unsolicited response with nothing tracked ----
        @(negedge clk); rstnn = 1'b1; #1;
        chk("unsol_s_yready", s_yready, 1'b0);
        chk("unsol_m_yvalid", m_yvalid, 1'b0);
        chk("idle_m_qready", m_qready, 1'b1);

        // ---- read len=3 at 0x100: one request beat, four responses ----
        rd = mkq(1'b0, 8'd3, 32'h0, 32'h100);
        @(negedge clk); m_qvalid = 1'b1; m_qparcel = rd; m_yready = 1'b0; #1;
        expect_q("rd_accept", 1'b0, 1'b0, '0);
        chk("rd_unsol_hold", m_yvalid, 1'b0);
        @(negedge clk); m_qvalid = 1'b0; #1;
        expect_q("rd_issue", 1'b1, 1'b1, rd);
        chk("rd_unsol_hold2", m_yvalid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); m_yready = 1'b1; s_yparcel = mky(i == 3, 32'hA0 + i); #1;
            if (i == 0) expect_q("rd_single", 1'b0, 1'b0, '0);
            chk("rd_s_yready", s_yready, 1'b1);
            expect_y($sformatf("rd_y%0d", i), i == 3, mky(i == 3, 32'hA0 + i));
        end
        @(negedge clk); #1;
        chk("rd_drained", m_yvalid, 1'b0);
        s_yvalid = 1'b0;

        // ---- write len=2: three beats, last on the third, one response ----
        for (int k = 0; k < 3; k++) w[k] = mkq(1'b1, 8'd2, 32'hD0 + k, 32'h200 + 4 * k);
        @(negedge clk); m_qvalid = 1'b1; m_qparcel = w[0]; #1;
        @(negedge clk); m_qparcel = w[1]; #1; expect_q("wr_b0", 1'b1, 1'b0, w[0]);
        @(negedge clk); m_qparcel = w[2]; #1; expect_q("wr_b1", 1'b1, 1'b0, w[1]);
        @(negedge clk); m_qvalid = 1'b0;   #1; expect_q("wr_b2", 1'b1, 1'b1, w[2]);
        @(negedge clk); s_yvalid = 1'b1; s_yparcel = mky(1'b1, 32'h0); #1;
        expect_q("wr_done", 1'b0, 1'b0, '0);
        expect_y("wr_resp", 1'b1, mky(1'b1, 32'h0));
        @(negedge clk); #1; chk("wr_drained", m_yvalid, 1'b0);
        s_yvalid = 1'b0;

        // ---- outstanding limit of 2 with three len=0 reads ----
        for (int k = 0; k < 3; k++) w[k] = mkq(1'b0, 8'd0, 32'h0, 32'h300 + k);
        @(negedge clk); m_qvalid = 1'b1; m_qparcel = w[0]; #1;
        @(negedge clk); m_qparcel = w[1]; #1; expect_q("mo_r0", 1'b1, 1'b1, w[0]);
        @(negedge clk); m_qparcel = w[2]; #1; expect_q("mo_r1", 1'b1, 1'b1, w[1]);
        @(negedge clk); m_qvalid = 1'b0;   #1; expect_q("mo_hold0", 1'b0, 1'b0, '0);
        chk("mo_m_qready", m_qready, 1'b1);
        @(negedge clk); #1; expect_q("mo_hold1", 1'b0, 1'b0, '0);
        @(negedge clk); s_yvalid = 1'b1; s_yparcel = mky(1'b0, 32'hB0); #1;
        expect_q("mo_hold2", 1'b0, 1'b0, '0);
        expect_y("mo_y0", 1'b1, mky(1'b0, 32'hB0));
        @(negedge clk); s_yvalid = 1'b0; #1; expect_q("mo_r2", 1'b1, 1'b1, w[2]);
        @(negedge clk); s_yvalid = 1'b1; #1; expect_y("mo_y1", 1'b1, mky(1'b0, 32'hB0));
        @(negedge clk); #1; expect_y("mo_y2", 1'b1, mky(1'b0, 32'hB0));
        @(negedge clk); #1; chk("mo_drained", m_yvalid, 1'b0);
        s_yvalid = 1'b0;

        // ---- enable dropped mid write burst ----
        for (int k = 0; k < 4; k++) w[k] = mkq(1'b1, 8'd3, 32'hE0 + k, 32'h400);
        w[4] = mkq(1'b0, 8'd0, 32'h0, 32'h500);
        rd2 = w[4];
        s_qready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); m_qvalid = 1'b1; m_qparcel = w[k]; #1;
            chk($sformatf("en_push%0d", k), m_qready, 1'b1);
        end
        @(negedge clk); m_qvalid = 1'b0; s_qready = 1'b1; #1; expect_q("en_w0", 1'b1, 1'b0, w[0]);
        @(negedge clk); enable = 1'b0; #1; expect_q("en_w1", 1'b1, 1'b0, w[1]);
        chk("en_m_qready_off", m_qready, 1'b0);
        @(negedge clk); #1; expect_q("en_w2", 1'b1, 1'b0, w[2]);
        @(negedge clk); #1; expect_q("en_w3", 1'b1, 1'b1, w[3]);
        @(negedge clk); #1; expect_q("en_stall0", 1'b0, 1'b0, '0);
        @(negedge clk); #1; expect_q("en_stall1", 1'b0, 1'b0, '0);
        @(negedge clk); enable = 1'b1; #1; expect_q("en_rd", 1'b1, 1'b1, rd2);
        @(negedge clk); s_yvalid = 1'b1; s_yparcel = mky(1'b0, 32'hC0); #1;
        expect_y("en_y_wr", 1'b1, mky(1'b0, 32'hC0));
        @(negedge clk); #1; expect_y("en_y_rd", 1'b1, mky(1'b0, 32'hC0));
        @(negedge clk); #1; chk("en_drained", m_yvalid, 1'b0);
        s_yvalid = 1'b0;

        // ---- clear in the middle of a write burst ----
        for (int k = 0; k < 4; k++) w[k] = mkq(1'b1, 8'd3, 32'hF0 + k, 32'h600);
        s_qready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); m_qvalid = 1'b1; m_qparcel = w[k]; #1;
        end
        @(negedge clk); m_qvalid = 1'b0; s_qready = 1'b1; #1; expect_q("clr_x0", 1'b1, 1'b0, w[0]);
        @(negedge clk); s_qready = 1'b0; #1; expect_q("clr_x1_wait", 1'b1, 1'b0, w[1]);
        @(negedge clk); clear = 1'b1; s_qready = 1'b1; m_qvalid = 1'b1; m_qparcel = w[3]; #1;
        chk("clr_m_qready", m_qready, 1'b0);
        expect_q("clr_blocked", 1'b0, 1'b0, '0);
        @(negedge clk); clear = 1'b0; m_qvalid = 1'b0; s_yvalid = 1'b1; #1;
        expect_q("clr_after", 1'b0, 1'b0, '0);
        chk("clr_after_m_qready", m_qready, 1'b1);
        chk("clr_outstanding0", m_yvalid, 1'b0);
        rd3 = mkq(1'b0, 8'd2, 32'h0, 32'h700);
        @(negedge clk); s_yvalid = 1'b0; m_qvalid = 1'b1; m_qparcel = rd3; #1;
        @(negedge clk); m_qvalid = 1'b0; #1; expect_q("clr_head", 1'b1, 1'b1, rd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); s_yvalid = 1'b1; s_yparcel = mky(1'b0, 32'h70 + i); #1;
            expect_y($sformatf("clr_y%0d", i), i == 2, mky(1'b0, 32'h70 + i));
        end
        @(negedge clk); #1; chk("clr_drained", m_yvalid, 1'b0);
        s_yvalid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
